// File: rtl/lcd_msg_driver.sv
// lcd_msg_driver
//   Drives an HD44780-style character LCD (8-bit bus, write only).
//   The driver waits out the power-up delay and sends the init commands.
//   It then rewrites line 1 whenever the message code on LCD_STATE differs
//   from the code currently shown.
//
// Parameters
//   POWERUP_CYC  - clocks to wait after reset before the first command
//   EN_CYC       - clocks LCD_EN is held high per byte
//   WAIT_CYC     - clocks LCD_EN is held low after a normal byte
//   CLR_WAIT_CYC - clocks LCD_EN is held low after the clear command 0x01
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   LCD_STATE in   [3:0] message code to display
//   LCD_DATA  out  [7:0] data bus
//   LCD_RS    out  0 = command, 1 = character
//   LCD_RW    out  tied to 0
//   LCD_EN    out  enable strobe
//   busy      out  low only while idle
//
// Configuration
//   LCD_LINE2_EN - when defined, each message also writes "IC TESTER V1"
//                  to line 2.

module lcd_msg_driver #(
    parameter int POWERUP_CYC  = 2000000,
    parameter int EN_CYC       = 25,
    parameter int WAIT_CYC     = 2500,
    parameter int CLR_WAIT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] LCD_STATE,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       busy
);

    // One counter serves every delay, so it is sized for the longest one.
    localparam int MAX_AB  = (POWERUP_CYC > CLR_WAIT_CYC) ? POWERUP_CYC : CLR_WAIT_CYC;
    localparam int MAX_CD  = (EN_CYC > WAIT_CYC) ? EN_CYC : WAIT_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int IW      = 4;  // index over 16 characters per line

    typedef enum logic [2:0] {
        PWRUP,
        INIT,
        IDLE,
        ADDR1,
        LINE1
`ifdef LCD_LINE2_EN
        ,
        ADDR2,
        LINE2
`endif
    } state_t;

    // Sub-phases of one byte write: data setup, strobe high, post-strobe wait.
    typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_t;

    state_t          state, nxt_state;
    phase_t          phase;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   wait_last;
    logic [IW-1:0]   idx, nxt_idx;
    logic [3:0]      shown;
    logic            force_msg;
    logic            nxt_send, nxt_rs;
    logic [7:0]      nxt_data;

    assign LCD_RW = 1'b0;

    function automatic logic [127:0] line1_text(input logic [3:0] code);
        case (code)
            4'd1:    return {"READY",       {11{" "}}};
            4'd2:    return {"TESTING...",  {6{" "}}};
            4'd3:    return {"PASS",        {12{" "}}};
            4'd4:    return {"FAIL",        {12{" "}}};
            4'd5:    return {"IC UNKNOWN",  {6{" "}}};
            4'd6:    return {"INVALID IC",  {6{" "}}};
            default: return {"STATE ERROR", {5{" "}}};
        endcase
    endfunction

`ifdef LCD_LINE2_EN
    localparam logic [127:0] LINE2_TEXT = {"IC TESTER V1", {4{" "}}};
`endif

    // Character 0 sits in the top byte of the packed string; ~i == 15 - i.
    function automatic logic [7:0] text_char(input logic [127:0] t, input logic [IW-1:0] i);
        logic [IW-1:0] ri;
        ri = ~i;
        return t[{ri, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] init_cmd(input logic [IW-1:0] i);
        case (i)
            4'd0:    return 8'h38;  // 8-bit bus, 2 lines, 5x8 font
            4'd1:    return 8'h0C;  // display on, cursor off
            4'd2:    return 8'h06;  // auto-increment, no shift
            default: return 8'h01;  // clear display
        endcase
    endfunction

    // The clear command needs the long post-strobe wait.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        wait_last = CW'(WAIT_CYC - 1);
        if (!LCD_RS && LCD_DATA == 8'h01)
            wait_last = CW'(CLR_WAIT_CYC - 1);
    end

    // Decides the byte that follows the one currently being written.
    always_comb begin
        nxt_state = IDLE;
        nxt_idx   = '0;
        nxt_send  = 1'b0;
        nxt_rs    = 1'b0;
        nxt_data  = 8'h00;
        case (state)
            INIT: begin
                if (idx != 4'd3) begin
                    nxt_state = INIT;
                    nxt_idx   = idx + 1'b1;
                    nxt_send  = 1'b1;
                    nxt_data  = init_cmd(idx + 1'b1);
                end
            end
            ADDR1: begin
                nxt_state = LINE1;
                nxt_send  = 1'b1;
                nxt_rs    = 1'b1;
                nxt_data  = text_char(line1_text(shown), '0);
            end
            LINE1: begin
                if (idx != 4'd15) begin
                    nxt_state = LINE1;
                    nxt_idx   = idx + 1'b1;
                    nxt_send  = 1'b1;
                    nxt_rs    = 1'b1;
                    nxt_data  = text_char(line1_text(shown), idx + 1'b1);
                end
`ifdef LCD_LINE2_EN
                else begin
                    nxt_state = ADDR2;
                    nxt_send  = 1'b1;
                    nxt_data  = 8'hC0;
                end
`endif
            end
`ifdef LCD_LINE2_EN
            ADDR2: begin
                nxt_state = LINE2;
                nxt_send  = 1'b1;
                nxt_rs    = 1'b1;
                nxt_data  = text_char(LINE2_TEXT, '0);
            end
            LINE2: begin
                if (idx != 4'd15) begin
                    nxt_state = LINE2;
                    nxt_idx   = idx + 1'b1;
                    nxt_send  = 1'b1;
                    nxt_rs    = 1'b1;
                    nxt_data  = text_char(LINE2_TEXT, idx + 1'b1);
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state     <= PWRUP;
            phase     <= PH_SETUP;
            cnt       <= '0;
            idx       <= '0;
            shown     <= 4'd0;
            force_msg <= 1'b1;  // guarantees the first message is written
            LCD_DATA  <= 8'h00;
            LCD_RS    <= 1'b0;
            LCD_EN    <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                PWRUP: begin
                    if (cnt == CW'(POWERUP_CYC - 1)) begin
                        state    <= INIT;
                        phase    <= PH_SETUP;
                        cnt      <= '0;
                        idx      <= '0;
                        LCD_DATA <= init_cmd('0);
                        LCD_RS   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    // The first byte is already presented on this edge.
                    if (LCD_STATE != shown || force_msg) begin
                        shown     <= LCD_STATE;
                        force_msg <= 1'b0;
                        state     <= ADDR1;
                        phase     <= PH_SETUP;
                        cnt       <= '0;
                        idx       <= '0;
                        LCD_DATA  <= 8'h80;
                        LCD_RS    <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    case (phase)
                        PH_SETUP: begin
                            LCD_EN <= 1'b1;
                            phase  <= PH_EN;
                            cnt    <= '0;
                        end
                        PH_EN: begin
                            if (cnt == CW'(EN_CYC - 1)) begin
                                LCD_EN <= 1'b0;
                                phase  <= PH_WAIT;
                                cnt    <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: begin
                            if (cnt == wait_last) begin
                                cnt   <= '0;
                                phase <= PH_SETUP;
                                state <= nxt_state;
                                idx   <= nxt_idx;
                                busy  <= (nxt_state != IDLE);
                                if (nxt_send) begin
                                    LCD_DATA <= nxt_data;
                                    LCD_RS   <= nxt_rs;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_msg_driver.md
LCD_MSG_DRIVER -- requirements
Module: lcd_msg_driver

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- POWERUP_CYC, 2000000, power-up wait before first command (40 ms at 50 MHz).
- EN_CYC, 25, LCD_EN high width in clocks.
- WAIT_CYC, 2500, post-strobe wait for normal bytes.
- CLR_WAIT_CYC, 100000, post-strobe wait after clear command 0x01.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- LCD_STATE, in, 4, message code from the LCD mux stage.
- LCD_DATA, out, 8, HD44780 data bus.
- LCD_RS, out, 1, 0 = command, 1 = character.
- LCD_RW, out, 1, always 0 (write only).
- LCD_EN, out, 1, HD44780 enable strobe.
- busy, out, 1, high whenever the FSM is not in IDLE.
REQ-003 The block SHALL run on one clock (clk) with a synchronous active-high reset (rst); there are no other clocks or asynchronous inputs.

Function
REQ-004 Byte write timing SHALL be as follows:
- Cycle 0: LCD_DATA and LCD_RS valid, LCD_EN = 0.
- Next EN_CYC cycles: LCD_EN = 1.
- Then LCD_EN = 0 for WAIT_CYC cycles, or CLR_WAIT_CYC after 0x01.
- LCD_DATA and LCD_RS SHALL stay stable for the whole byte.
REQ-005 FSM states SHALL be PWRUP, INIT, IDLE, ADDR1, LINE1, ADDR2, LINE2.
REQ-006 PWRUP SHALL wait POWERUP_CYC cycles, then go to INIT.
REQ-007 INIT SHALL send commands 0x38, 0x0C, 0x06, 0x01 in that order, then go to IDLE.
REQ-008 IDLE SHALL go to ADDR1 when LCD_STATE differs from the latched shown code, or when the force flag is set; the transition SHALL latch the shown code and clear the force flag.
REQ-009 ADDR1 SHALL send command 0x80, then LINE1 SHALL send 16 characters (RS = 1) for the latched code, in index order 0..15.
REQ-010 Line-1 text, ASCII, space-padded to 16 characters:
- 1 "READY"
- 2 "TESTING..."
- 3 "PASS"
- 4 "FAIL"
- 5 "IC UNKNOWN"
- 6 "INVALID IC"
- 0 and 7-15 "STATE ERROR"
REQ-011 After LINE1, the FSM SHALL go to ADDR2 when LCD_LINE2_EN is defined, otherwise to IDLE.
REQ-012 A LCD_STATE change during a message SHALL NOT abort it; the message in progress completes, then IDLE detects the mismatch and rewrites.
REQ-013 Multiple LCD_STATE changes during one message SHALL produce exactly one rewrite, using the value sampled on return to IDLE.
REQ-014 A LCD_STATE glitch that returns to the shown code before IDLE SHALL cause no rewrite.
REQ-015 The latency from a LCD_STATE change in IDLE to the first ADDR1 byte cycle SHALL be 1 clock.
REQ-016 All delay and character counters SHALL be sized from the parameters, and SHALL never wrap within a single delay.
REQ-017 LCD_RW SHALL be constant 0.
REQ-018 busy SHALL be 0 only in IDLE.

Reset
REQ-019 While rst = 1, the block SHALL hold LCD_EN = 0, LCD_RS = 0, LCD_RW = 0, LCD_DATA = 0x00 and busy = 1.
REQ-020 On reset, the FSM SHALL go to PWRUP, all counters SHALL be 0, and the force flag SHALL be set so the first message is always written.
REQ-021 Reset asserted mid-byte SHALL drop LCD_EN on the next clock and restart the full power-up and init sequence.

Configuration
REQ-022 The macro LCD_LINE2_EN SHALL control line 2:
- Defined: ADDR2 sends 0xC0, then LINE2 sends "IC TESTER V1" space-padded to 16 characters, then IDLE.
- Undefined: the ADDR2 and LINE2 states and their text ROM are not compiled.

Verification
REQ-023 The bench SHALL use parameter overrides POWERUP_CYC = 20, EN_CYC = 2, WAIT_CYC = 4, CLR_WAIT_CYC = 8 and cover:
- V1: reset, LCD_STATE = 1 -> after 20 cycles, commands 0x38, 0x0C, 0x06, 0x01, then 0x80, then "READY" plus 11 spaces; busy falls in IDLE.
- V2: in IDLE, LCD_STATE 1 -> 3 -> next cycle busy = 1; bytes 0x80, then "PASS" plus 12 spaces.
- V3: LCD_STATE 3 -> 4 -> 6 during the line-1 write -> current message completes; exactly one rewrite, "INVALID IC".
- V4: LCD_STATE = 9 -> "STATE ERROR" plus 5 spaces; LCD_STATE 4 -> 9 -> 4 within one message -> no extra rewrite.
- V5: rst pulsed during the EN-high phase of a character -> LCD_EN = 0 next cycle; full init sequence replays.
- V6: with LCD_LINE2_EN defined -> 0xC0 and "IC TESTER V1" follow line 1; every strobe is exactly 2 cycles high, with data stable across it.
